clken_synth: RTL and testbench

Multi-channel fractional clock-enable synthesiser, the parametrised successor of the fixed single-output PLL wrapper.
Runs entirely in the refclk domain and generates CHANNELS independent clock-enable strobes. Each strobe has a run-time programmable rational rate: f_ref*inc/2^ACC_WIDTH.
Each channel has its own lock/settle sequencing, so video timing generators can retune pixel rates without touching the hard PLL.

---
 rtl/clken_synth_pkg.sv | 20 ++
 rtl/clken_nco_chan.sv | 87 ++++++++
 rtl/clken_synth.sv | 91 +++++++++
 tb/tb_clken_synth.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clken_synth_pkg.sv
// Shared types and helpers for the fractional clock-enable synthesiser.
package clken_synth_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SETTLING = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } cfg_state_e;

  // Channel-index width; a single channel still gets a 1-bit select.
  function automatic int chan_idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/clken_nco_chan.sv
// One enable channel: phase accumulator, inc/phase registers, settle counter and lock FSM.
//
// state    | meaning
// UNLOCKED | disabled, inc=0, or not yet started settling
// SETTLING | counting refclk cycles since enable or last apply
// LOCKED   | settle time elapsed, strobes are at the programmed rate
module clken_nco_chan
  import clken_synth_pkg::*;
#(
  parameter int ACC_WIDTH     = 32,
  parameter int SETTLE_CYCLES = 1024,
  parameter logic [ACC_WIDTH-1:0] INC_RESET = '0
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ACC_WIDTH-1:0] wr_inc,
  input  logic [ACC_WIDTH-1:0] wr_phase,
  input  logic                 chan_en,
  output logic                 clken,
  output logic                 locked
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] inc_q;
  logic [ACC_WIDTH-1:0] phase_q;
  logic [ACC_WIDTH-1:0] inc_eff;
  logic [ACC_WIDTH:0]   sum;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 en_q;
  lock_state_e          st;

  assign sum     = {1'b0, acc} + {1'b0, inc_q};
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign inc_eff = wr_en ? wr_inc : inc_q;
  assign locked  = (st == LOCKED);

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      acc     <= '0;
      inc_q   <= INC_RESET;
      phase_q <= '0;
      clken   <= 1'b0;
      en_q    <= 1'b0;
      cnt     <= '0;
      st      <= UNLOCKED;
    end else begin
      if (wr_en) begin
        inc_q   <= wr_inc;
        phase_q <= wr_phase;
      end
      clken <= 1'b0;
      if (!chan_en) begin
        acc  <= phase_q;
        en_q <= 1'b0;
        cnt  <= '0;
        st   <= UNLOCKED;
      end else if (wr_en || !en_q) begin
        // Load edge: a fresh enable or an apply restarts phase and settling.
        acc  <= wr_en ? wr_phase : phase_q;
        en_q <= 1'b1;
        cnt  <= '0;
        st   <= (inc_eff != '0) ? SETTLING : UNLOCKED;
      end else begin
        {clken, acc} <= sum;
        case (st)
          UNLOCKED: begin
            if (inc_q != '0) begin
              st  <= SETTLING;
              cnt <= '0;
            end
          end
          SETTLING: begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_MAX) st <= LOCKED;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/clken_synth.sv
// Multi-channel fractional clock-enable synthesiser: config handshake, write decode and lock summary.
//
// state | meaning
// IDLE  | cfg_ready high, waiting for a request
// APPLY | captured request is written to its channel at the end of this cycle
module clken_synth
  import clken_synth_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int ACC_WIDTH     = 32,
  parameter int SETTLE_CYCLES = 1024,
  parameter logic [ACC_WIDTH-1:0] INC_RESET = '0
) (
  input  logic                              refclk,
  input  logic                              rst_n,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [chan_idx_w(CHANNELS)-1:0]   cfg_chan,
  input  logic [ACC_WIDTH-1:0]              cfg_inc,
  input  logic [ACC_WIDTH-1:0]              cfg_phase,
  input  logic [CHANNELS-1:0]               chan_en,
  output logic [CHANNELS-1:0]               clken,
  output logic [CHANNELS-1:0]               locked,
  output logic                              locked_all,
  output logic                              cfg_err
);

  localparam int CW = chan_idx_w(CHANNELS);

  cfg_state_e           st;
  logic [CW-1:0]        chan_q;
  logic [ACC_WIDTH-1:0] inc_q;
  logic [ACC_WIDTH-1:0] phase_q;
  logic                 chan_ok;
  logic [CHANNELS-1:0]  wr_en;

  assign chan_ok = (32'(chan_q) < 32'(CHANNELS));

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      st         <= IDLE;
      cfg_ready  <= 1'b0;
      cfg_err    <= 1'b0;
      locked_all <= 1'b0;
      chan_q     <= '0;
      inc_q      <= '0;
      phase_q    <= '0;
    end else begin
      cfg_err    <= 1'b0;
      locked_all <= &locked;
      case (st)
        IDLE: begin
          if (cfg_valid && cfg_ready) begin
            st        <= APPLY;
            cfg_ready <= 1'b0;
            chan_q    <= cfg_chan;
            inc_q     <= cfg_inc;
            phase_q   <= cfg_phase;
          end else begin
            cfg_ready <= 1'b1;
          end
        end
        APPLY: begin
          st        <= IDLE;
          cfg_ready <= 1'b1;
          cfg_err   <= !chan_ok;
        end
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign wr_en[g] = (st == APPLY) && chan_ok && (chan_q == CW'(g));

    clken_nco_chan #(
      .ACC_WIDTH    (ACC_WIDTH),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .INC_RESET    (INC_RESET)
    ) u_chan (
      .refclk  (refclk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[g]),
      .wr_inc  (inc_q),
      .wr_phase(phase_q),
      .chan_en (chan_en[g]),
      .clken   (clken[g]),
      .locked  (locked[g])
    );
  end

endmodule

// File: tb/tb_clken_synth.sv
// Bench for clken_synth: directed and random steps checked against a rate/lock reference model.
module tb_clken_synth;

  localparam int W      = 8;
  localparam int SETTLE = 16;
  localparam int NCH    = 2;

  logic         refclk;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [0:0]   cfg_chan;
  logic [W-1:0] cfg_inc;
  logic [W-1:0] cfg_phase;
  logic [1:0]   chan_en;
  logic [1:0]   clken;
  logic [1:0]   locked;
  logic         locked_all;
  logic         cfg_err;

  // Three-channel instance: its 2-bit select can address a channel that does not exist.
  logic         cfg_valid3;
  logic         cfg_ready3;
  logic [1:0]   cfg_chan3;
  logic [2:0]   chan_en3;
  logic [2:0]   clken3;
  logic [2:0]   locked3;
  logic         locked_all3;
  logic         cfg_err3;

  clken_synth #(.CHANNELS(2), .ACC_WIDTH(W), .SETTLE_CYCLES(SETTLE), .INC_RESET(8'd0)) u_dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .chan_en(chan_en),
    .clken(clken), .locked(locked), .locked_all(locked_all), .cfg_err(cfg_err)
  );

  clken_synth #(.CHANNELS(3), .ACC_WIDTH(W), .SETTLE_CYCLES(SETTLE), .INC_RESET(8'd64)) u_dut3 (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_chan(cfg_chan3), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .chan_en(chan_en3),
    .clken(clken3), .locked(locked3), .locked_all(locked_all3), .cfg_err(cfg_err3)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: strobe k fires when floor((phase + k*inc) / 2^W) steps up;
  // lock holds once SETTLE cycles have elapsed since the settle start.
  longint m_inc[NCH];
  longint m_ph[NCH];
  int     m_run[NCH];
  int     m_since[NCH];
  bit     m_clk[NCH];
  bit     m_ready, m_err, m_lall, m_pend;
  int     m_pch;
  longint m_pinc, m_pph;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit m_locked(input int c);
    return m_since[c] >= SETTLE;
  endfunction

  task automatic model_edge();
    bit all_l;
    bit ap;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_inc[c] = 0; m_ph[c] = 0; m_run[c] = -1; m_since[c] = -1; m_clk[c] = 0;
      end
      m_ready = 0; m_err = 0; m_lall = 0; m_pend = 0;
      return;
    end
    all_l = 1;
    for (int c = 0; c < NCH; c++) all_l &= m_locked(c);
    m_lall = all_l;
    m_err  = m_pend && (m_pch >= NCH);
    for (int c = 0; c < NCH; c++) begin
      ap = m_pend && (m_pch == c);
      if (ap) begin
        m_inc[c] = m_pinc;
        m_ph[c]  = m_pph;
      end
      m_clk[c] = 0;
      if (!chan_en[c]) begin
        m_run[c] = -1; m_since[c] = -1;
      end else if (ap || m_run[c] < 0) begin
        m_run[c] = 0; m_since[c] = (m_inc[c] != 0) ? 0 : -1;
      end else begin
        m_run[c]++;
        m_clk[c] = ((m_ph[c] + m_run[c] * m_inc[c]) >> W) !=
                   ((m_ph[c] + (m_run[c] - 1) * m_inc[c]) >> W);
        if (m_since[c] >= 0) m_since[c]++;
        else if (m_inc[c] != 0) m_since[c] = 0;
      end
    end
    if (m_ready && cfg_valid) begin
      m_pend = 1; m_pch = int'(cfg_chan); m_pinc = longint'(cfg_inc); m_pph = longint'(cfg_phase);
      m_ready = 0;
    end else begin
      m_pend = 0; m_ready = 1;
    end
  endtask

  task automatic step();
    @(posedge refclk);
    model_edge();
    @(negedge refclk);
    chk("clken", 64'(clken), 64'({m_clk[1], m_clk[0]}));
    chk("locked", 64'(locked), 64'({m_locked(1), m_locked(0)}));
    chk("locked_all", 64'(locked_all), 64'(m_lall));
    chk("cfg_ready", 64'(cfg_ready), 64'(m_ready));
    chk("cfg_err", 64'(cfg_err), 64'(m_err));
  endtask

  task automatic cfg_write(input int ch, input int inc, input int ph);
    bit accepted;
    bit rdy;
    accepted  = 0;
    cfg_valid = 1'b1;
    cfg_chan  = 1'(ch);
    cfg_inc   = W'(inc);
    cfg_phase = W'(ph);
    for (int i = 0; i < 8 && !accepted; i++) begin
      rdy = cfg_ready;
      step();
      if (rdy) accepted = 1;
    end
    cfg_valid = 1'b0;
    if (!accepted) chk("cfg_accept", 64'(accepted), 64'(1));
  endtask

  initial begin
    int n, first, nstr, last, k, nerr, nbad;
    bit got;
    rst_n = 1'b0; chan_en = 2'b11; cfg_valid = 1'b0; cfg_chan = '0; cfg_inc = '0; cfg_phase = '0;
    cfg_valid3 = 1'b0; cfg_chan3 = '0; chan_en3 = '0;
    m_ready = 0; m_err = 0; m_lall = 0; m_pend = 0; m_pch = 0; m_pinc = 0; m_pph = 0;
    for (int c = 0; c < NCH; c++) begin
      m_inc[c] = 0; m_ph[c] = 0; m_run[c] = -1; m_since[c] = -1; m_clk[c] = 0;
    end

    // Reset held three cycles with both channels requested on.
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1; chan_en = 2'b00;
    step();
    chk("ready_after_rst", 64'(cfg_ready), 64'(1));

    // Basic rate: inc=64 -> strobe every 4 cycles, lock 16 cycles after enable.
    cfg_write(0, 64, 0);
    step();
    chan_en[0] = 1'b1;
    n = 0; got = 0; first = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (clken[0] && first < 0) first = n;
      n++;
      if (locked[0]) got = 1;
    end
    chk("lock0_seen", 64'(got), 64'(1));
    chk("lock0_delay", 64'(n - 1), 64'(SETTLE));
    chk("first_strobe", 64'(first), 64'(4));
    chk("locked_all_ch1_off", 64'(locked_all), 64'(0));

    // Fractional rate: inc=96 -> strobe k lands at ceil(256k/96) cycles after enable.
    cfg_write(1, 96, 0);
    step();
    chan_en[1] = 1'b1;
    step();
    nstr = 0; k = 1;
    for (int t = 1; t <= 24; t++) begin
      step();
      if (clken[1]) begin
        chk("frac_time", 64'(t), 64'((256 * k + 95) / 96));
        k++;
        nstr++;
      end
    end
    chk("frac_count", 64'(nstr), 64'(9));
    for (int i = 0; i < 4; i++) step();

    // Retune ch0 while locked, followed back-to-back by another write.
    cfg_write(0, 128, 0);
    chk("ready_in_apply", 64'(cfg_ready), 64'(0));
    cfg_write(1, 96, 0);
    chk("lock0_dropped", 64'(locked[0]), 64'(0));
    n = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      n++;
      if (locked[0]) got = 1;
    end
    chk("relock0_seen", 64'(got), 64'(1));
    chk("relock0_delay", 64'(n + 1), 64'(SETTLE));
    for (int i = 0; i < 6; i++) step();

    // inc=0 while enabled: no strobes and never locks.
    cfg_write(1, 0, 0);
    nstr = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (clken[1]) nstr++;
    end
    chk("inc0_strobes", 64'(nstr), 64'(0));
    chk("inc0_locked", 64'(locked[1]), 64'(0));

    // Enable dropped mid-settle, then restarted with a nonzero phase.
    cfg_write(0, 200, 77);
    for (int i = 0; i < 5; i++) step();
    chan_en[0] = 1'b0;
    step();
    chk("drop_unlocked", 64'(locked[0]), 64'(0));
    step();
    chan_en[0] = 1'b1;
    for (int i = 0; i < 24; i++) step();

    // Apply and enable fall on the same edge; the new registers still take effect.
    cfg_write(0, 48, 10);
    chan_en[0] = 1'b0;
    step();
    chan_en[0] = 1'b1;
    for (int i = 0; i < 24; i++) step();

    // Random traffic with one mid-run reset.
    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (it == 40) begin
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
      end else if (r <= 2) begin
        cfg_write($urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255),
                  $urandom_range(0, 255));
      end else if (r == 3) begin
        chan_en[$urandom_range(0, 1)] ^= 1'b1;
        step();
      end else begin
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) step();
      end
    end
    chan_en = 2'b00;
    step();

    // Out-of-range channel write on the three-channel instance.
    chan_en3 = 3'b001;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (locked3[0]) got = 1;
    end
    chk("dut3_locked", 64'(got), 64'(1));
    cfg_chan3 = 2'd3; cfg_inc = 8'd128; cfg_phase = 8'd5;
    chk("dut3_ready", 64'(cfg_ready3), 64'(1));
    cfg_valid3 = 1'b1;
    step();
    cfg_valid3 = 1'b0;
    chk("bad_err_apply_cycle", 64'(cfg_err3), 64'(0));
    step();
    chk("bad_err_pulse", 64'(cfg_err3), 64'(1));
    chk("bad_locked_kept", 64'(locked3), 64'(3'b001));
    nstr = 0; nerr = 0; nbad = 0; last = -1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (cfg_err3) nerr++;
      if (clken3[0]) begin
        if (last >= 0) chk("bad_period", 64'(i - last), 64'(4));
        last = i;
        nstr++;
      end
      if (clken3[2:1] != 2'b00) nbad++;
    end
    chk("bad_err_once", 64'(nerr), 64'(0));
    chk("bad_rate_kept", 64'(nstr), 64'(4));
    chk("bad_other_chans", 64'(nbad), 64'(0));
    chk("bad_locked_end", 64'(locked3), 64'(3'b001));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
